// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 message scheduler.
// Contents: block/digest widths, block-counter width, initial hash value,
// and the scheduler state encoding.
package sha256_pkg;

  localparam int unsigned BLOCK_W  = 512;
  localparam int unsigned DIGEST_W = 256;
  localparam int unsigned CNT_W    = 16;

  // FIPS 180-4 initial hash value, H0 in the MSBs
  localparam logic [DIGEST_W-1:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sha256_rr_arbiter.sv
// Round-robin arbiter with a message lock.
// Ports:
//   req     - request vector, one bit per requester
//   ptr     - highest-priority requester index for the next unlocked grant
//   lock    - a message is in progress; only lock_id may be granted
//   lock_id - owner of the locked message
//   gnt     - one-hot (or zero) grant, combinational
module sha256_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               lock,
  input  logic [ID_W-1:0]    lock_id,
  output logic [NUM_REQ-1:0] gnt
);

  // Unlocked: scan from the farthest offset down so the nearest requester
  // at or after ptr is the last (winning) assignment.
  always_comb begin
    gnt = '0;
    if (lock) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (lock_id == ID_W'(i)) gnt[i] = req[i];
      end
    end else begin
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
          if (req[i] && (i == (int'(ptr) + k) % int'(NUM_REQ))) begin
            gnt    = '0;
            gnt[i] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/sha256_msg_scheduler.sv
// Shares one SHA-256 compression core between NUM_REQ requesters.
// Blocks arrive pre-padded over valid/ready; a requester keeps the core
// until its last block. The chaining value is kept per message (IV on the
// first block) and the final digest is returned tagged with the owner.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   req_valid/ready/block/last      - per-requester block input
//   core_start/block/hin            - compression request to the core
//   core_done/hout                  - compression result from the core
//   dig_valid/ready/data/id/blocks  - final digest output
//   busy                            - mid-transaction or message locked
module sha256_msg_scheduler
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_block,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic                       core_start,
  output logic [BLOCK_W-1:0]         core_block,
  output logic [DIGEST_W-1:0]        core_hin,
  input  logic                       core_done,
  input  logic [DIGEST_W-1:0]        core_hout,
  output logic                       dig_valid,
  input  logic                       dig_ready,
  output logic [DIGEST_W-1:0]        dig_data,
  output logic [ID_W-1:0]            dig_id,
  output logic [CNT_W-1:0]           dig_blocks,
  output logic                       busy
);

  sched_state_t state, state_nxt;

  logic                lock, lock_nxt;
  logic [ID_W-1:0]     owner, rr_ptr, rr_next, acc_id;
  logic                last_q, acc_last;
  logic [DIGEST_W-1:0] chain;
  logic [CNT_W-1:0]    blk_cnt;
  logic [NUM_REQ-1:0]  gnt;
  logic [BLOCK_W-1:0]  acc_block;
  logic                accept, done_evt, out_hs, busy_nxt;

  sha256_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .lock    (lock),
    .lock_id (owner),
    .gnt     (gnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = ISSUE;
      ISSUE:                  state_nxt = WAIT;
      WAIT:    if (core_done) state_nxt = last_q ? OUT : IDLE;
      OUT:     if (dig_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake decode; ready is held low while reset is asserted
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst) req_ready = gnt;
    accept   = |req_ready;
    done_evt = (state == WAIT) && core_done;
    out_hs   = (state == OUT) && dig_ready;
    lock_nxt = lock;
    if (done_evt) lock_nxt = !last_q;
    busy_nxt = (state_nxt != IDLE) || lock_nxt;
    rr_next  = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);
  end

  // Select the granted requester's block
  always_comb begin
    acc_id    = '0;
    acc_block = '0;
    acc_last  = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        acc_id    = ID_W'(i);
        acc_block = req_block[i*BLOCK_W +: BLOCK_W];
        acc_last  = req_last[i];
      end
    end
  end

  // Block, chaining and digest registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lock       <= 1'b0;
      owner      <= '0;
      rr_ptr     <= '0;
      last_q     <= 1'b0;
      chain      <= '0;
      blk_cnt    <= '0;
      core_start <= 1'b0;
      core_block <= '0;
      core_hin   <= '0;
      dig_valid  <= 1'b0;
      dig_data   <= '0;
      dig_id     <= '0;
      dig_blocks <= '0;
      busy       <= 1'b0;
    end else begin
      core_start <= accept;
      lock       <= lock_nxt;
      busy       <= busy_nxt;
      if (accept) begin
        core_block <= acc_block;
        last_q     <= acc_last;
        owner      <= acc_id;
        core_hin   <= lock ? chain : SHA256_IV;
        if (!lock)                blk_cnt <= CNT_W'(1);
        else if (blk_cnt != '1)   blk_cnt <= blk_cnt + CNT_W'(1);
      end
      if (done_evt) begin
        chain <= core_hout;
        if (last_q) begin
          dig_valid  <= 1'b1;
          dig_data   <= core_hout;
          dig_id     <= owner;
          dig_blocks <= blk_cnt;
          rr_ptr     <= rr_next;
        end
      end
      if (out_hs) dig_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Scoreboard bench for sha256_msg_scheduler with a behavioural SHA-256 core.
module tb_sha256_msg_scheduler;
  import sha256_pkg::*;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ID_W    = 1;
  localparam int unsigned DW      = DIGEST_W;
  localparam int          LAT     = 64;
  localparam int          TMO     = 1000;

  localparam logic [BLOCK_W-1:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [BLOCK_W-1:0] B1_BLK = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [BLOCK_W-1:0] B2_BLK = {{15{32'h0}}, 32'h000001c0};
  localparam logic [DW-1:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [DW-1:0] TWO_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [ID_W-1:0] id;
    logic [15:0]     blocks;
  } dig_exp_t;

  logic                       clk;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid, req_ready, req_last;
  logic [BLOCK_W-1:0]         blk_in [NUM_REQ];
  logic [NUM_REQ*BLOCK_W-1:0] req_block;
  logic                       core_start, core_done, model_done, spur_done;
  logic [BLOCK_W-1:0]         core_block;
  logic [DW-1:0]              core_hin, core_hout, model_hout, spur_val;
  logic                       dig_valid, dig_ready, busy;
  logic [DW-1:0]              dig_data;
  logic [ID_W-1:0]            dig_id;
  logic [15:0]                dig_blocks;

  int       n_vec, n_err, cyc, acc_cyc, done_cyc, cnt;
  logic     prev_start, prev_dv;
  logic [ID_W-1:0] gid;
  dig_exp_t de;
  logic [DW-1:0] h1;

  dig_exp_t        dig_q [$];
  logic [ID_W-1:0] gnt_q [$];
  logic [DW-1:0]   hin_q [$];

  assign req_block = {blk_in[1], blk_in[0]};
  assign core_done = model_done | spur_done;
  assign core_hout = spur_done ? spur_val : model_hout;

  sha256_msg_scheduler #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_block  (req_block),
    .req_last   (req_last),
    .core_start (core_start),
    .core_block (core_block),
    .core_hin   (core_hin),
    .core_done  (core_done),
    .core_hout  (core_hout),
    .dig_valid  (dig_valid),
    .dig_ready  (dig_ready),
    .dig_data   (dig_data),
    .dig_id     (dig_id),
    .dig_blocks (dig_blocks),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [DW-1:0] sha_compress(input logic [DW-1:0] hin, input logic [BLOCK_W-1:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
             (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req_ready"},  DW'(req_ready), '0);
    check({tag, ".core_start"}, DW'(core_start), '0);
    check({tag, ".core_block"}, DW'(core_block != '0), '0);
    check({tag, ".core_hin"},   core_hin, '0);
    check({tag, ".dig_valid"},  DW'(dig_valid), '0);
    check({tag, ".dig_data"},   dig_data, '0);
    check({tag, ".dig_id"},     DW'(dig_id), '0);
    check({tag, ".dig_blocks"}, DW'(dig_blocks), '0);
    check({tag, ".busy"},       DW'(busy), '0);
  endtask

  // Present one block and hold it until accepted; returns on the next negedge
  task automatic send(input logic [ID_W-1:0] id, input logic [BLOCK_W-1:0] blk, input logic last);
    int n;
    n = 0;
    blk_in[id]    = blk;
    req_last[id]  = last;
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && n < TMO) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= TMO) fail_now("send_timeout");
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((busy || dig_q.size() != 0) && n < TMO);
    if (n >= TMO) fail_now("idle_timeout");
  endtask

  // Behavioural core: done LAT cycles after start, hout = hin + compression
  initial begin
    cnt = 0; prev_start = 1'b0; done_cyc = -10;
    model_done = 1'b0; model_hout = '0;
    forever begin
      @(negedge clk); #1;
      model_done = 1'b0;
      if (rst) begin
        cnt = 0;
        prev_start = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            model_done = 1'b1;
            done_cyc = cyc;
          end
        end
        if (core_start) begin
          check("start_single", DW'(prev_start), '0);
          check("start_latency", DW'(cyc), DW'(acc_cyc + 1));
          if (hin_q.size() == 0) fail_now("unexpected_core_start");
          else check("core_hin", core_hin, hin_q.pop_front());
          model_hout = sha_compress(core_hin, core_block);
          cnt = LAT;
        end
        prev_start = core_start;
      end
    end
  end

  // Grant monitor
  initial begin
    acc_cyc = -10;
    forever begin
      @(negedge clk); #2;
      if (|(req_valid & req_ready)) begin
        gid = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) if (req_ready[i]) gid = ID_W'(i);
        acc_cyc = cyc;
        check("grant_onehot", DW'($onehot(req_ready)), DW'(1));
        if (gnt_q.size() == 0) fail_now("unexpected_grant");
        else check("grant_id", DW'(gid), DW'(gnt_q.pop_front()));
      end
    end
  end

  // Digest monitor
  initial begin
    prev_dv = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (dig_valid && !prev_dv) check("dig_latency", DW'(cyc), DW'(done_cyc + 1));
      prev_dv = dig_valid;
      if (dig_valid && dig_ready) begin
        if (dig_q.size() == 0) fail_now("unexpected_digest");
        else begin
          de = dig_q.pop_front();
          check("dig_data", dig_data, de.data);
          check("dig_id", DW'(dig_id), DW'(de.id));
          check("dig_blocks", DW'(dig_blocks), DW'(de.blocks));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; req_valid = '0; req_last = '0; dig_ready = 1'b1;
    spur_done = 1'b0; spur_val = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) blk_in[i] = '0;
    h1 = sha_compress(SHA256_IV, B1_BLK);
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single-block "abc"
    gnt_q.push_back(1'b0); hin_q.push_back(SHA256_IV);
    dig_q.push_back('{ABC_DIG, 1'b0, 16'd1});
    send(1'b0, ABC_BLK, 1'b1);
    wait_idle();

    // Two-block message on req0 while req1 waits
    gnt_q.push_back(1'b0); gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
    hin_q.push_back(SHA256_IV); hin_q.push_back(h1); hin_q.push_back(SHA256_IV);
    dig_q.push_back('{TWO_DIG, 1'b0, 16'd2}); dig_q.push_back('{ABC_DIG, 1'b1, 16'd1});
    fork
      begin send(1'b0, B1_BLK, 1'b0); send(1'b0, B2_BLK, 1'b1); end
      begin @(negedge clk); send(1'b1, ABC_BLK, 1'b1); end
    join
    wait_idle();

    // Round-robin after reset, back-to-back single-block messages
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gnt_q.push_back(ID_W'(i % 2)); hin_q.push_back(SHA256_IV);
      dig_q.push_back('{ABC_DIG, ID_W'(i % 2), 16'd1});
    end
    fork
      begin send(1'b0, ABC_BLK, 1'b1); send(1'b0, ABC_BLK, 1'b1); end
      begin send(1'b1, ABC_BLK, 1'b1); send(1'b1, ABC_BLK, 1'b1); end
    join
    wait_idle();

    // Back-pressured digest with spurious core_done in OUT
    dig_ready = 1'b0;
    gnt_q.push_back(1'b0); hin_q.push_back(SHA256_IV);
    send(1'b0, ABC_BLK, 1'b1);
    blk_in[1] = ABC_BLK; req_last[1] = 1'b1; req_valid[1] = 1'b1;
    begin
      int n;
      n = 0;
      while (!dig_valid && n < TMO) begin @(negedge clk); #1; n++; end
      if (n >= TMO) fail_now("dig_valid_timeout");
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      spur_done = 1'b0;
      check("hold.dig_valid", DW'(dig_valid), DW'(1));
      check("hold.dig_data", dig_data, ABC_DIG);
      check("hold.dig_id", DW'(dig_id), '0);
      check("hold.dig_blocks", DW'(dig_blocks), DW'(1));
      check("hold.req_ready", DW'(req_ready), '0);
      if (i == 1) begin
        spur_val  = {8{$urandom()}};
        spur_done = 1'b1;
      end
    end
    @(negedge clk);
    dig_q.push_back('{ABC_DIG, 1'b0, 16'd1});
    gnt_q.push_back(1'b1); hin_q.push_back(SHA256_IV);
    dig_q.push_back('{ABC_DIG, 1'b1, 16'd1});
    dig_ready = 1'b1;
    @(negedge clk); #1;
    check("accept_after_hs", DW'(req_ready), DW'(2'b10));
    send(1'b1, ABC_BLK, 1'b1);
    wait_idle();

    // Reset while WAITing on block 1 of a two-block message
    gnt_q.push_back(1'b0); hin_q.push_back(SHA256_IV);
    send(1'b0, B1_BLK, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check_all_zero("midreset");
    gnt_q.push_back(1'b0); gnt_q.push_back(1'b0);
    hin_q.push_back(SHA256_IV); hin_q.push_back(h1);
    dig_q.push_back('{TWO_DIG, 1'b0, 16'd2});
    send(1'b0, B1_BLK, 1'b0);
    send(1'b0, B2_BLK, 1'b1);
    wait_idle();

    // Spurious core_done in IDLE, unlocked then locked
    spur_val = {8{$urandom()}}; spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    #1 check("spur_idle.busy", DW'(busy), '0);
    check("spur_idle.dig_valid", DW'(dig_valid), '0);
    gnt_q.push_back(1'b0); hin_q.push_back(SHA256_IV);
    send(1'b0, B1_BLK, 1'b0);
    begin
      int n;
      n = 0;
      do begin @(negedge clk); #2; n++; end while (!model_done && n < TMO);
      if (n >= TMO) fail_now("core_done_timeout");
    end
    @(negedge clk);
    spur_val = {8{$urandom()}}; spur_done = 1'b1;
    #1 check("locked.busy", DW'(busy), DW'(1));
    check("locked.req_ready", DW'(req_ready), '0);
    @(negedge clk);
    spur_done = 1'b0;
    gnt_q.push_back(1'b0); hin_q.push_back(h1);
    dig_q.push_back('{TWO_DIG, 1'b0, 16'd2});
    send(1'b0, B2_BLK, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    check("gnt_q_empty", DW'(gnt_q.size()), '0);
    check("hin_q_empty", DW'(hin_q.size()), '0);
    check("dig_q_empty", DW'(dig_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_msg_scheduler.md
# sha256_msg_scheduler

Controller that shares one SHA-256 compression core between `NUM_REQ` requesters. It accepts 512-bit pre-padded message blocks over valid/ready, and arbitrates round-robin at message boundaries, so a requester keeps the core until its last block. It keeps the chaining value per message, loading the IV on the first block and the previous digest otherwise, and sequences the core with a start/done handshake. It returns the final 256-bit digest tagged with the requester ID.

## Interface
- `NUM_REQ`, 2: number of requesters (≥1).
- `ID_W`, `$clog2(NUM_REQ)` (min 1): requester ID width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: requester i has a block.
- `req_ready` out `NUM_REQ`: one-hot grant. A block transfers when `req_valid[i] & req_ready[i]`.
- `req_block` in `NUM_REQ*512`: slice i is `[i*512 +: 512]`. Word W0 is in bits `[511:480]`.
- `req_last` in `NUM_REQ`: block is the final block of its message.
- `core_start` out 1: one-cycle pulse that starts a compression.
- `core_block` out 512: block under compression, held stable from start to done.
- `core_hin` out 256: chaining input, H0 in `[255:224]`, held stable from start to done.
- `core_done` in 1: one-cycle pulse; `core_hout` is valid in that cycle.
- `core_hout` in 256: `core_hin` plus the compression result (feed-forward add done in the core).
- `dig_valid` out 1: digest available.
- `dig_ready` in 1: digest consumer accepts.
- `dig_data` out 256: final hash, H0 in the MSBs.
- `dig_id` out `ID_W`: requester that owns `dig_data`.
- `dig_blocks` out 16: blocks in the message, saturating at 16'hFFFF.
- `busy` out 1: state ≠ IDLE or a message is locked.

## Operation
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE, unlocked:
  - Grant the first `req_valid` bit at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - `req_ready` is combinational and asserted only in IDLE.
- IDLE, locked: only `req_ready[owner]` can assert, when `req_valid[owner]` is high. Other requesters stall.
- Transfer in IDLE, then go to ISSUE:
  - Register the block, `last`, and `owner`.
  - `core_hin` = IV when unlocked, else `chain`.
  - `blk_cnt` = 1 when unlocked, else `blk_cnt+1` (saturating).
- ISSUE: `core_start`=1 for exactly one cycle, then go to WAIT.
- WAIT, on `core_done`:
  - `chain` ← `core_hout`.
  - If last: latch `dig_data`/`dig_id`/`dig_blocks`, set `dig_valid`, clear the lock, set `rr_ptr` ← `owner+1` (mod `NUM_REQ`), go to OUT.
  - If not last: set the lock and go to IDLE.
- OUT: hold all `dig_*` outputs stable until `dig_ready`. On handshake, clear `dig_valid` and go to IDLE. No block is accepted in OUT.
- `core_done` outside WAIT is ignored and changes no state.
- All 32-bit words use modulo-2^32 arithmetic, inside the core only. This block does no arithmetic except `blk_cnt` and `rr_ptr`.
- A single-block message (`last`=1 on its first block) never locks.

## Timing
- Reset values:
  - All outputs 0: `req_ready`, `core_start`, `core_block`, `core_hin`, `dig_valid`, `dig_data`, `dig_id`, `dig_blocks`, `busy`.
  - Internal: state IDLE, lock clear, `rr_ptr`=0, `chain`=0.
- Reset mid-message (any state): the message is abandoned and no digest is emitted. The next accepted block starts from the IV.
- Accept at cycle T → `core_start` at T+1 → `core_done` at T+1+L (L≥1, core latency) → `dig_valid` at T+2+L.
- Block throughput for a locked message: the next accept is no earlier than T+2+L.
- Simultaneous `req_valid` from all requesters: exactly one `req_ready` bit is set, chosen by the round-robin rule above.
- If `dig_ready` is already high when `dig_valid` rises, the handshake completes in that cycle. The block returns to IDLE on the next cycle.

## Structure
- Package `sha256_pkg`:
  - `SHA256_IV` = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - `BLOCK_W`=512, `DIGEST_W`=256.
  - Enum `sched_state_t`.
- Sub-module `sha256_rr_arbiter`: parameterised `NUM_REQ`. Inputs `req`, `ptr`, `lock`, `lock_id`. Output one-hot `gnt`.
- Top level: FSM, block/chain registers, block counter.

## Test plan
- Single-block "abc" on req0:
  - Stimulus: block 61626380 000…0 00000018, `last`=1, behavioural core model with L=64.
  - Required: `core_hin`=IV, `core_start` one cycle after accept.
  - Required: `dig_data`=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, `dig_id`=0, `dig_blocks`=1.
- Two-block "abcdbcde…nopq" on req0 with req1 valid throughout:
  - Required: req1 is never granted before req0's last block.
  - Required: block-2 `core_hin` equals block-1 `core_hout`.
  - Required: digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, `dig_blocks`=2.
- Round-robin after reset, req0 and req1 both sending single-block messages back to back: grant order 0, 1, 0, 1.
- `dig_ready` held low 5 cycles:
  - Required: `dig_*` stable throughout, `req_ready`=0 throughout.
  - Required: accept possible on the cycle after the handshake.
- `rst` pulse in WAIT of a 2-block message:
  - Required: all outputs 0 the next cycle, no `dig_valid`.
  - Required: resending block 1 yields `core_hin`=IV.
- Spurious `core_done` in IDLE and in OUT: no state change, `chain` unchanged.
